// File: rtl/brew_sensor_frontend.sv
// rtl/brew_sensor_frontend.sv - two-channel ADC sequencer, averager and 8-bit scaler for the brew FSM
module brew_sensor_frontend #(
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 255,
    parameter int GAP      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        adc_done,
    input  logic [11:0] adc_data,
    input  logic        fault_clr,
    output logic        adc_start,
    output logic        adc_ch,
    output logic [7:0]  temp,
    output logic [7:0]  level,
    output logic        upd,
    output logic        ready,
    output logic        fault
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] AVG_N  = CNT_W'(1 << AVG_LOG2);
    localparam logic [7:0]       GAP_LIM = 8'(GAP);
    // Timeout fires in the WAIT cycle whose increment would reach TIMEOUT.
    localparam logic [7:0]       TO_LIM  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_GAPW = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_ACC  = 2'd3
    } state_t;

    state_t             r_state;
    logic [7:0]         r_gap_cnt;
    logic [7:0]         r_to_cnt;
    logic [11:0]        r_sample;
    logic [ACC_W-1:0]   r_acc0;
    logic [ACC_W-1:0]   r_acc1;
    logic [CNT_W-1:0]   r_cnt0;
    logic [CNT_W-1:0]   r_cnt1;
    logic               r_seen0;
    logic               r_seen1;
    logic               r_start;
    logic               r_ch;
    logic [7:0]         r_temp;
    logic [7:0]         r_level;
    logic               r_upd;
    logic               r_ready;
    logic               r_fault;

    logic [ACC_W-1:0]   w_acc_cur;
    logic [ACC_W-1:0]   w_acc_sum;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_avg_done;
    logic               w_timeout;
    logic [7:0]         w_avg;

    assign w_acc_cur  = r_ch ? r_acc1 : r_acc0;
    assign w_acc_sum  = w_acc_cur + ACC_W'(r_sample);
    assign w_cnt_next = (r_ch ? r_cnt1 : r_cnt0) + CNT_W'(1);
    assign w_avg_done = (w_cnt_next == AVG_N);
    // Top 8 bits of the full sum: average scaled from 12 to 8 bits, truncated.
    assign w_avg      = w_acc_sum[ACC_W-1 -: 8];
    assign w_timeout  = (r_to_cnt == TO_LIM);

    assign adc_start = r_start;
    assign adc_ch    = r_ch;
    assign temp      = r_temp;
    assign level     = r_level;
    assign upd       = r_upd;
    assign ready     = r_ready;
    assign fault     = r_fault;

    // Conversion sequencer, accumulators and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_GAPW;
            r_gap_cnt <= 8'd0;
            r_to_cnt  <= 8'd0;
            r_sample  <= 12'd0;
            r_acc0    <= '0;
            r_acc1    <= '0;
            r_cnt0    <= '0;
            r_cnt1    <= '0;
            r_seen0   <= 1'b0;
            r_seen1   <= 1'b0;
            r_start   <= 1'b0;
            r_ch      <= 1'b0;
            r_temp    <= 8'd0;
            r_level   <= 8'd0;
            r_upd     <= 1'b0;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            // Clear first so a timeout set later in this block takes priority.
            if (fault_clr) begin
                r_fault <= 1'b0;
            end
            case (r_state)
                S_GAPW: begin
                    if (r_gap_cnt == GAP_LIM) begin
                        r_gap_cnt <= 8'd0;
                        r_start   <= 1'b1;
                        r_state   <= S_REQ;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end
                S_REQ: begin
                    r_start  <= 1'b0;
                    r_to_cnt <= 8'd0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    r_to_cnt <= r_to_cnt + 8'd1;
                    if (adc_done) begin
                        r_sample <= adc_data;
                        r_state  <= S_ACC;
                    end else if (w_timeout) begin
                        // Sample lost; channel is kept so the same one is retried.
                        r_fault   <= 1'b1;
                        r_gap_cnt <= 8'd0;
                        r_state   <= S_GAPW;
                    end
                end
                S_ACC: begin
                    if (w_avg_done) begin
                        if (r_ch) begin
                            r_level <= w_avg;
                            r_acc1  <= '0;
                            r_cnt1  <= '0;
                            r_seen1 <= 1'b1;
                            r_ready <= r_ready | r_seen0;
                        end else begin
                            r_temp  <= w_avg;
                            r_acc0  <= '0;
                            r_cnt0  <= '0;
                            r_seen0 <= 1'b1;
                            r_ready <= r_ready | r_seen1;
                        end
                        r_upd <= 1'b1;
                    end else begin
                        if (r_ch) begin
                            r_acc1 <= w_acc_sum;
                            r_cnt1 <= w_cnt_next;
                        end else begin
                            r_acc0 <= w_acc_sum;
                            r_cnt0 <= w_cnt_next;
                        end
                    end
                    r_ch      <= ~r_ch;
                    r_gap_cnt <= 8'd0;
                    r_state   <= S_GAPW;
                end
                default: begin
                    r_state <= S_GAPW;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brew_sensor_frontend.sv
// tb/tb_brew_sensor_frontend.sv - directed self-checking bench for brew_sensor_frontend
module tb_brew_sensor_frontend;

    logic        clk = 1'b0;
    logic        reset;
    logic        adc_done;
    logic [11:0] adc_data;
    logic        fault_clr;
    logic        adc_start;
    logic        adc_ch;
    logic [7:0]  temp;
    logic [7:0]  level;
    logic        upd;
    logic        ready;
    logic        fault;

    logic        reset_b;
    logic        adc_done_b;
    logic [11:0] adc_data_b;
    logic        fault_clr_b;
    logic        adc_start_b;
    logic        adc_ch_b;
    logic [7:0]  temp_b;
    logic [7:0]  level_b;
    logic        upd_b;
    logic        ready_b;
    logic        fault_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_start = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    brew_sensor_frontend u_dut (
        .clk       (clk),
        .reset     (reset),
        .adc_done  (adc_done),
        .adc_data  (adc_data),
        .fault_clr (fault_clr),
        .adc_start (adc_start),
        .adc_ch    (adc_ch),
        .temp      (temp),
        .level     (level),
        .upd       (upd),
        .ready     (ready),
        .fault     (fault)
    );

    brew_sensor_frontend #(.AVG_LOG2(2), .TIMEOUT(255), .GAP(0)) u_dut_g0 (
        .clk       (clk),
        .reset     (reset_b),
        .adc_done  (adc_done_b),
        .adc_data  (adc_data_b),
        .fault_clr (fault_clr_b),
        .adc_start (adc_start_b),
        .adc_ch    (adc_ch_b),
        .temp      (temp_b),
        .level     (level_b),
        .upd       (upd_b),
        .ready     (ready_b),
        .fault     (fault_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input logic exp_ch);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!adc_start && n < 2000);
        chk("start_seen", 32'(adc_start), 32'd1);
        chk("adc_ch", 32'(adc_ch), 32'(exp_ch));
        last_start = cyc;
    endtask

    task automatic respond(input logic [11:0] d, input int dly, output logic u);
        repeat (dly) @(posedge clk);
        #1;
        adc_done = 1'b1;
        adc_data = d;
        @(posedge clk);
        #1;
        adc_done = 1'b0;
        adc_data = 12'h000;
        @(posedge clk);
        #1;
        u = upd;
    endtask

    task automatic conv(input logic exp_ch, input logic [11:0] d, output logic u);
        wait_start(exp_ch);
        respond(d, 2, u);
    endtask

    logic u;
    int   ups;
    int   t_prev;
    int   t1;
    int   n;
    logic [11:0] t2_data [4];

    initial begin
        reset       = 1'b0;
        adc_done    = 1'b0;
        adc_data    = 12'h000;
        fault_clr   = 1'b0;
        reset_b     = 1'b0;
        adc_done_b  = 1'b0;
        adc_data_b  = 12'h000;
        fault_clr_b = 1'b0;
        t2_data[0] = 12'h0FF;
        t2_data[1] = 12'h100;
        t2_data[2] = 12'h101;
        t2_data[3] = 12'h102;

        // 1: reset values, then steady alternation
        repeat (3) @(posedge clk);
        #1;
        chk("rst_temp", 32'(temp), 32'h00);
        chk("rst_level", 32'(level), 32'h00);
        chk("rst_start", 32'(adc_start), 32'd0);
        chk("rst_ch", 32'(adc_ch), 32'd0);
        chk("rst_upd_ready_fault", {29'd0, upd, ready, fault}, 32'd0);
        reset = 1'b1;
        ups = 0;
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            conv(i[0], i[0] ? 12'h400 : 12'hA00, u);
            ups += int'(u);
            if (i == 1) chk("spacing", 32'(last_start - t_prev), 32'd8);
            t_prev = last_start;
            if (i == 6) begin
                chk("t1_temp", 32'(temp), 32'hA0);
                chk("t1_level_pre", 32'(level), 32'h00);
                chk("t1_ready_pre", 32'(ready), 32'd0);
            end
        end
        chk("t1_level", 32'(level), 32'h40);
        chk("t1_ready", 32'(ready), 32'd1);
        chk("t1_upd_count", 32'(ups), 32'd2);

        // 2: truncation and full-scale
        for (int i = 0; i < 8; i++) begin
            conv(i[0], i[0] ? 12'h800 : t2_data[i / 2], u);
        end
        chk("t2_temp_trunc", 32'(temp), 32'h10);
        chk("t2_level", 32'(level), 32'h80);
        for (int i = 0; i < 8; i++) begin
            conv(i[0], 12'hFFF, u);
        end
        chk("t2_temp_max", 32'(temp), 32'hFF);
        chk("t2_level_max", 32'(level), 32'hFF);

        // 3: timeout on ch1, retry same channel, clear fault
        conv(1'b0, 12'h400, u);
        wait_start(1'b1);
        repeat (255) @(posedge clk);
        #1;
        chk("t3_fault_pre", 32'(fault), 32'd0);
        @(posedge clk);
        #1;
        chk("t3_fault_set", 32'(fault), 32'd1);
        chk("t3_temp_hold", 32'(temp), 32'hFF);
        chk("t3_level_hold", 32'(level), 32'hFF);
        wait_start(1'b1);
        respond(12'h800, 2, u);
        fault_clr = 1'b1;
        @(posedge clk);
        #1;
        fault_clr = 1'b0;
        chk("t3_fault_clr", 32'(fault), 32'd0);

        // 4: done on the last allowed cycle, spurious done in GAPW
        wait_start(1'b0);
        respond(12'h400, 255, u);
        chk("t4_late_done_fault", 32'(fault), 32'd0);
        adc_done = 1'b1;
        adc_data = 12'hFFF;
        @(posedge clk);
        #1;
        adc_done = 1'b0;
        adc_data = 12'h000;
        conv(1'b1, 12'h800, u);
        conv(1'b0, 12'h400, u);
        chk("t4_upd_early", 32'(u), 32'd0);
        conv(1'b1, 12'h800, u);
        conv(1'b0, 12'h400, u);
        chk("t4_upd", 32'(u), 32'd1);
        chk("t4_temp", 32'(temp), 32'h40);

        // 5: reset in WAIT with three ch0 samples pending
        conv(1'b1, 12'h800, u);
        chk("t5_level_upd", 32'(u), 32'd1);
        chk("t5_level", 32'(level), 32'h80);
        for (int i = 0; i < 5; i++) begin
            conv(i[0], i[0] ? 12'h800 : 12'hFFF, u);
        end
        wait_start(1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("t5_rst_temp", 32'(temp), 32'h00);
        chk("t5_rst_level", 32'(level), 32'h00);
        chk("t5_rst_start", 32'(adc_start), 32'd0);
        chk("t5_rst_ready", 32'(ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        adc_done = 1'b1;
        adc_data = 12'hFFF;
        @(posedge clk);
        #1;
        adc_done = 1'b0;
        adc_data = 12'h000;
        for (int i = 0; i < 7; i++) begin
            conv(i[0], i[0] ? 12'h000 : 12'h400, u);
            if (i == 0) chk("t5_no_stale_upd", 32'(u), 32'd0);
            if (i == 4) chk("t5_upd_early", 32'(u), 32'd0);
        end
        chk("t5_upd", 32'(u), 32'd1);
        chk("t5_temp", 32'(temp), 32'h40);
        chk("t5_level_zero", 32'(level), 32'h00);

        // 6: timeout coinciding with fault_clr, then GAP=0 spacing
        wait_start(1'b1);
        repeat (255) @(posedge clk);
        #1;
        chk("t6_fault_pre", 32'(fault), 32'd0);
        fault_clr = 1'b1;
        @(posedge clk);
        #1;
        fault_clr = 1'b0;
        chk("t6_set_wins", 32'(fault), 32'd1);
        wait_start(1'b1);
        respond(12'h000, 2, u);

        reset_b = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!adc_start_b && n < 100);
        chk("g0_start1", 32'(adc_start_b), 32'd1);
        t1 = cyc;
        @(posedge clk);
        #1;
        adc_done_b = 1'b1;
        adc_data_b = 12'h123;
        @(posedge clk);
        #1;
        adc_done_b = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!adc_start_b && n < 100);
        chk("g0_start2", 32'(adc_start_b), 32'd1);
        chk("g0_spacing", 32'(cyc - t1), 32'd4);
        chk("g0_ch", 32'(adc_ch_b), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
